mem_vis_arbiter: RTL and testbench
==================================

# mem_vis_arbiter

N-port arbiter between cache-side requesters (I-cache, D-cache, future vector/DMA ports) and the single main-memory visit interface. It replaces the fixed two-port split into main memory with a parametrised port count. It latches one request per transaction, drives main memory with registered signals, and returns data and status to the granted port only. Arbitration is round-robin, or fixed priority when the configuration macro is absent.

## Interface
Parameters:
- `N_PORTS`, 2: number of requesters, ≥2.
- `PORT_INDEX_SIZE`, 1: clog2(N_PORTS).
- `ADDR_WIDTH`, 17: memory address width.
- `LEN`, 32: data word width.
- `ENTRY_INDEX_SIZE`, 3: length field is ENTRY_INDEX_SIZE+1 bits.

Ports (port p occupies slice [p*W +: W] of each flattened bus):
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_vis_signal` in 2*N_PORTS: per port, 00 = IDLE, 01 = READ, 10 = WRITE, 11 = reserved (treated as IDLE).
- `req_addr` in ADDR_WIDTH*N_PORTS.
- `req_written_data` in LEN*N_PORTS.
- `req_data_type` in 3*N_PORTS.
- `req_length` in (ENTRY_INDEX_SIZE+1)*N_PORTS.
- `rsp_status` out 2*N_PORTS: per port, 00 = IDLE, 01 = BUSY, 10 = FINISHED.
- `rsp_data` out LEN: read data, valid only where a port's status is FINISHED.
- `grant_id` out PORT_INDEX_SIZE: port currently owning memory.
- `mem_vis_signal` out 2, `mem_vis_addr` out ADDR_WIDTH, `mem_written_data` out LEN, `mem_data_type` out 3, `mem_write_length` out ENTRY_INDEX_SIZE+1: registered drive to main memory.
- `mem_data` in LEN, `mem_status` in 2: main-memory response; FINISHED = 10.

## Operation
The arbiter has three states: IDLE, WAIT and RESPOND.

- **IDLE**
  - No active requests: remain in IDLE.
  - Active requests present: select a winner and latch its vis_signal/addr/data/type/length into the `mem_*` registers.
  - Set `grant_id` to the winner and go to WAIT.
- **WAIT**
  - Hold all `mem_*` outputs constant.
  - When `mem_status` = FINISHED, capture `mem_data` into `rsp_data`, drive `mem_vis_signal` to IDLE and go to RESPOND.
- **RESPOND**
  - Drive `rsp_status[grant_id]` = FINISHED for exactly one cycle, then return to IDLE.

Per-port `rsp_status`:
- FINISHED for the granted port in RESPOND.
- Otherwise BUSY while that port's request is active or it is granted.
- Otherwise IDLE.

Requester rules:
- A requester holds its request non-IDLE until it sees FINISHED.
- It drops the request at the clock edge that ends the FINISHED cycle.
- Request fields may change after grant; the arbiter uses only latched copies.

Boundary cases:
- A granted port withdrawing its request mid-transaction is ignored; the transaction completes and FINISHED still pulses.
- A non-granted port withdrawing is allowed and has no effect.
- A request arriving during WAIT or RESPOND waits for the next IDLE.
- Reserved code 11 is never granted.
- Every transaction has at least one IDLE `mem_vis_signal` cycle (RESPOND) before the next one.
- Reset in any state: state = IDLE, all `mem_*` = 0 (`mem_vis_signal` = IDLE), `rsp_status` all IDLE, `rsp_data` = 0, `grant_id` = 0, round-robin pointer = 0. An in-flight memory access is abandoned.

## Timing
- Request present in IDLE at cycle 0 → `mem_vis_signal` valid in cycle 1.
- `mem_status` = FINISHED in cycle k → `rsp_status` = FINISHED and `rsp_data` valid in cycle k+1.
- Back-to-back transactions: next grant is sampled in the IDLE cycle k+2, and memory is driven in cycle k+3.
- Arbitration overhead is 2 cycles per transaction beyond memory latency.
- All outputs are registered; no combinational path from `mem_status` to `rsp_*`.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - A pointer holds (last grant + 1) mod N_PORTS and is updated on every grant.
  - The winner is the first active port found searching upward from the pointer, with wrap-around.
  - A continuously requesting port waits at most N_PORTS−1 transactions.
- `MEM_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: the lowest-index active port wins.
  - The pointer logic is absent.
  - Starvation of high-index ports is permitted.

## Test plan
- Single read: port 1 READ addr 0x00040, memory returns 0xDEADBEEF after 3 cycles → port 1 FINISHED for one cycle with `rsp_data` 0xDEADBEEF; port 0 status stays IDLE.
- Simultaneous requests: N_PORTS=4, all ports request continuously.
  - With `MEM_ARB_ROUND_ROBIN_EN`: grant order 0,1,2,3,0.
  - Without it: port 0 is granted on every transaction.
- Write latching: port 0 WRITE addr 0x00100, data 0x12345678, type 2, length 1, then changes its fields the cycle after grant → memory sees the original values unchanged until FINISHED.
- Withdrawal: the granted port drops its request during WAIT → FINISHED still pulses once, then the arbiter returns to IDLE. A non-granted port dropping its request is never granted.
- Reset mid-WAIT: assert `rst` asynchronously between clock edges → `mem_vis_signal` = 00 and all `rsp_status` = 00 immediately; the first post-reset grant goes to port 0.
- Reserved code: port 0 drives 11 and port 1 drives READ → port 1 is granted and port 0 status reads IDLE.

Source files
------------

// File: rtl/mem_vis_arbiter_if.sv
// mem_vis_arbiter_if: requester-side and main-memory-side buses of mem_vis_arbiter.
//   req_*  : flattened per-port requests (port p at slice [p*W +: W])
//   rsp_*  : per-port status, shared read data, grant_id of the owning port
//   mem_*  : registered drive to main memory plus its data/status response
//   slave  : arbiter view; master: environment (requesters + memory) view
interface mem_vis_arbiter_if #(
    parameter int N_PORTS          = 2,
    parameter int PORT_INDEX_SIZE  = 1,
    parameter int ADDR_WIDTH       = 17,
    parameter int LEN              = 32,
    parameter int ENTRY_INDEX_SIZE = 3
);
    logic [2*N_PORTS-1:0]                    req_vis_signal;
    logic [ADDR_WIDTH*N_PORTS-1:0]           req_addr;
    logic [LEN*N_PORTS-1:0]                  req_written_data;
    logic [3*N_PORTS-1:0]                    req_data_type;
    logic [(ENTRY_INDEX_SIZE+1)*N_PORTS-1:0] req_length;
    logic [2*N_PORTS-1:0]                    rsp_status;
    logic [LEN-1:0]                          rsp_data;
    logic [PORT_INDEX_SIZE-1:0]              grant_id;
    logic [1:0]                              mem_vis_signal;
    logic [ADDR_WIDTH-1:0]                   mem_vis_addr;
    logic [LEN-1:0]                          mem_written_data;
    logic [2:0]                              mem_data_type;
    logic [ENTRY_INDEX_SIZE:0]               mem_write_length;
    logic [LEN-1:0]                          mem_data;
    logic [1:0]                              mem_status;

    modport slave (
        input  req_vis_signal, req_addr, req_written_data, req_data_type, req_length,
        input  mem_data, mem_status,
        output rsp_status, rsp_data, grant_id,
        output mem_vis_signal, mem_vis_addr, mem_written_data, mem_data_type, mem_write_length
    );

    modport master (
        output req_vis_signal, req_addr, req_written_data, req_data_type, req_length,
        output mem_data, mem_status,
        input  rsp_status, rsp_data, grant_id,
        input  mem_vis_signal, mem_vis_addr, mem_written_data, mem_data_type, mem_write_length
    );
endinterface

// File: rtl/mem_vis_arbiter.sv
// mem_vis_arbiter: N-port arbiter onto the single main-memory visit interface.
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : mem_vis_arbiter_if.slave (requests in, per-port status/data out, memory drive/response)
// Arbitration is round-robin when MEM_ARB_ROUND_ROBIN_EN is defined, else fixed lowest-index priority.
module mem_vis_arbiter #(
    parameter int N_PORTS          = 2,
    parameter int PORT_INDEX_SIZE  = 1,
    parameter int ADDR_WIDTH       = 17,
    parameter int LEN              = 32,
    parameter int ENTRY_INDEX_SIZE = 3
) (
    input logic              clk,
    input logic              rst,
    mem_vis_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_FIN  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;

    state_t                     state;
    logic [N_PORTS-1:0]         active;
    logic [PORT_INDEX_SIZE-1:0] win;
    logic                       found;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [PORT_INDEX_SIZE-1:0] ptr;
`endif

    // 01 and 10 are the only codes with odd parity; reserved 11 counts as idle
    for (genvar i = 0; i < N_PORTS; i++) begin : g_active
        assign active[i] = ^bus.req_vis_signal[2*i +: 2];
    end

    // i-th port visited by the search
    function automatic logic [PORT_INDEX_SIZE-1:0] slot(input int i);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return PORT_INDEX_SIZE'((int'(ptr) + i) % N_PORTS);
`else
        return PORT_INDEX_SIZE'(i);
`endif
    endfunction

    // scan backwards so the earliest slot in search order is the last write
    always_comb begin
        found = 1'b0;
        win = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (active[slot(i)]) begin
                found = 1'b1;
                win = slot(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            bus.grant_id <= '0;
            bus.rsp_status <= '0;
            bus.rsp_data <= '0;
            bus.mem_vis_signal <= ST_IDLE;
            bus.mem_vis_addr <= '0;
            bus.mem_written_data <= '0;
            bus.mem_data_type <= '0;
            bus.mem_write_length <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr <= '0;
`endif
        end else begin
            for (int p = 0; p < N_PORTS; p++)
                bus.rsp_status[2*p +: 2] <= active[p] ? ST_BUSY : ST_IDLE;
            case (state)
                S_IDLE: if (found) begin
                    state <= S_WAIT;
                    bus.grant_id <= win;
                    bus.mem_vis_signal <= bus.req_vis_signal[2*win +: 2];
                    bus.mem_vis_addr <= bus.req_addr[ADDR_WIDTH*win +: ADDR_WIDTH];
                    bus.mem_written_data <= bus.req_written_data[LEN*win +: LEN];
                    bus.mem_data_type <= bus.req_data_type[3*win +: 3];
                    bus.mem_write_length <= bus.req_length[(ENTRY_INDEX_SIZE+1)*win +: ENTRY_INDEX_SIZE+1];
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    ptr <= (win == PORT_INDEX_SIZE'(N_PORTS - 1)) ? '0 : win + 1'b1;
`endif
                end
                // the granted port stays BUSY even if it has withdrawn its request
                S_WAIT: if (bus.mem_status == ST_FIN) begin
                    state <= S_RESPOND;
                    bus.rsp_data <= bus.mem_data;
                    bus.mem_vis_signal <= ST_IDLE;
                    bus.rsp_status[2*bus.grant_id +: 2] <= ST_FIN;
                end else begin
                    bus.rsp_status[2*bus.grant_id +: 2] <= ST_BUSY;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_vis_arbiter.sv
// tb_mem_vis_arbiter: directed scoreboard bench for a 4-port mem_vis_arbiter.
module tb_mem_vis_arbiter;
    localparam int NP = 4;
    localparam int PI = 2;
    localparam int AW = 17;
    localparam int DW = 32;
    localparam int EI = 3;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   mem_lat = 3;
    int   mem_cnt = 0;
    int   fin_cyc;
    logic [2*NP-1:0] fin_status;
    exp_t sb[$];

    mem_vis_arbiter_if #(.N_PORTS(NP), .PORT_INDEX_SIZE(PI), .ADDR_WIDTH(AW), .LEN(DW), .ENTRY_INDEX_SIZE(EI)) bus ();

    mem_vis_arbiter #(.N_PORTS(NP), .PORT_INDEX_SIZE(PI), .ADDR_WIDTH(AW), .LEN(DW), .ENTRY_INDEX_SIZE(EI)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_model(input logic [AW-1:0] a);
        return (a == 17'h00040) ? 32'hDEADBEEF : (32'h5A5A0000 ^ {15'h0, a});
    endfunction

    // main-memory stub: FINISHED for one cycle, mem_lat cycles after the access appears
    always @(negedge clk) begin
        bus.mem_status = 2'b00;
        if (bus.mem_vis_signal != 2'b00) begin
            mem_cnt = mem_cnt + 1;
            if (mem_cnt == mem_lat) begin
                bus.mem_status = 2'b10;
                bus.mem_data = mem_model(bus.mem_vis_addr);
            end
        end else begin
            mem_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic [1:0] v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [2:0] t, input logic [EI:0] l);
        bus.req_vis_signal[2*p +: 2] = v;
        bus.req_addr[AW*p +: AW] = a;
        bus.req_written_data[DW*p +: DW] = d;
        bus.req_data_type[3*p +: 3] = t;
        bus.req_length[(EI+1)*p +: EI+1] = l;
    endtask

    task automatic push(input int p, input logic [AW-1:0] a);
        exp_t e;
        e.port = p;
        e.data = mem_model(a);
        sb.push_back(e);
    endtask

    // wait for a FINISHED pulse, compare against the scoreboard head, then check it lasts one cycle
    task automatic wait_finish(input bit drop);
        exp_t e;
        int   p;
        bit   got;
        got = 1'b0;
        p = 0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            for (int i = 0; i < NP; i++)
                if (bus.rsp_status[2*i +: 2] == 2'b10) begin
                    got = 1'b1;
                    p = i;
                end
        end
        checks++;
        assert (got && sb.size() > 0) else begin
            errors++;
            $error("FAIL finish_timeout: observed got=%0d pending=%0d expected got=1", got, sb.size());
        end
        if (got && sb.size() > 0) begin
            fin_cyc = cyc;
            fin_status = bus.rsp_status;
            e = sb.pop_front();
            check("fin_port", 64'(p), 64'(e.port));
            check("fin_grant_id", 64'(bus.grant_id), 64'(e.port));
            check("fin_rsp_data", 64'(bus.rsp_data), 64'(e.data));
            if (drop) bus.req_vis_signal[2*p +: 2] = 2'b00;
            @(negedge clk);
            check("fin_one_cycle", 64'(bus.rsp_status[2*p +: 2] == 2'b10), 64'd0);
            check("mem_idle_gap", 64'(bus.mem_vis_signal), 64'd0);
        end
    endtask

    initial begin
        int t0;
        rst = 1'b1;
        bus.req_vis_signal = '0;
        bus.req_addr = '0;
        bus.req_written_data = '0;
        bus.req_data_type = '0;
        bus.req_length = '0;
        bus.mem_data = '0;
        bus.mem_status = '0;
        repeat (2) @(negedge clk);
        check("rst_mem_vis", 64'(bus.mem_vis_signal), 64'd0);
        check("rst_rsp_status", 64'(bus.rsp_status), 64'd0);
        check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        check("rst_grant", 64'(bus.grant_id), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_vis_addr), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // single read from port 1, memory latency 3
        mem_lat = 3;
        set_req(1, 2'b01, 17'h00040, 32'h0, 3'd0, 4'd0);
        push(1, 17'h00040);
        t0 = cyc;
        @(negedge clk);
        check("rd_mem_vis", 64'(bus.mem_vis_signal), 64'd1);
        check("rd_mem_addr", 64'(bus.mem_vis_addr), 64'h40);
        check("rd_grant", 64'(bus.grant_id), 64'd1);
        check("rd_status_busy", 64'(bus.rsp_status), 64'h04);
        wait_finish(1'b1);
        check("rd_latency", 64'(fin_cyc - t0), 64'd4);
        check("rd_status_fin", 64'(fin_status), 64'h08);

        // write latching: fields change after grant, memory keeps the originals
        mem_lat = 4;
        set_req(0, 2'b10, 17'h00100, 32'h12345678, 3'd2, 4'd1);
        push(0, 17'h00100);
        @(negedge clk);
        check("wr_latch_c1", {bus.mem_vis_signal, bus.mem_vis_addr, bus.mem_written_data, bus.mem_data_type, bus.mem_write_length},
              {2'b10, 17'h00100, 32'h12345678, 3'd2, 4'd1});
        set_req(0, 2'b10, 17'h1FFFF, 32'hFFFFFFFF, 3'd7, 4'd15);
        repeat (2) begin
            @(negedge clk);
            check("wr_latch_hold", {bus.mem_vis_signal, bus.mem_vis_addr, bus.mem_written_data, bus.mem_data_type, bus.mem_write_length},
                  {2'b10, 17'h00100, 32'h12345678, 3'd2, 4'd1});
        end
        wait_finish(1'b1);

        // withdrawal: granted port 2 and waiting port 3 both drop during WAIT
        mem_lat = 3;
        set_req(2, 2'b01, 17'h00200, 32'h0, 3'd0, 4'd0);
        set_req(3, 2'b01, 17'h00300, 32'h0, 3'd0, 4'd0);
        push(2, 17'h00200);
        @(negedge clk);
        check("wd_grant", 64'(bus.grant_id), 64'd2);
        bus.req_vis_signal[5:4] = 2'b00;
        bus.req_vis_signal[7:6] = 2'b00;
        wait_finish(1'b1);
        repeat (5) @(negedge clk);
        check("wd_no_grant3", 64'(bus.grant_id), 64'd2);
        check("wd_mem_idle", 64'(bus.mem_vis_signal), 64'd0);
        check("wd_status_idle", 64'(bus.rsp_status), 64'd0);

        // reserved code 11 on port 0 is never granted
        set_req(0, 2'b11, 17'h00080, 32'h0, 3'd0, 4'd0);
        set_req(1, 2'b01, 17'h00044, 32'h0, 3'd0, 4'd0);
        push(1, 17'h00044);
        @(negedge clk);
        check("rsv_grant", 64'(bus.grant_id), 64'd1);
        check("rsv_status0", 64'(bus.rsp_status[1:0]), 64'd0);
        wait_finish(1'b1);
        check("rsv_status0_after", 64'(bus.rsp_status[1:0]), 64'd0);
        bus.req_vis_signal[1:0] = 2'b00;
        repeat (2) @(negedge clk);

        // asynchronous reset in the middle of a long WAIT
        mem_lat = 20;
        set_req(3, 2'b01, 17'h00010, 32'h0, 3'd0, 4'd0);
        repeat (3) @(negedge clk);
        check("rw_in_wait", 64'(bus.mem_vis_signal), 64'd1);
        @(posedge clk);
        #3;
        set_req(0, 2'b01, 17'h00020, 32'h0, 3'd0, 4'd0);
        rst = 1'b1;
        #1;
        check("rw_mem_vis", 64'(bus.mem_vis_signal), 64'd0);
        check("rw_rsp_status", 64'(bus.rsp_status), 64'd0);
        check("rw_rsp_data", 64'(bus.rsp_data), 64'd0);
        check("rw_grant", 64'(bus.grant_id), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        mem_lat = 2;
        push(0, 17'h00020);
        push(3, 17'h00010);
        @(negedge clk);
        check("rw_first_grant", 64'(bus.grant_id), 64'd0);
        check("rw_first_addr", 64'(bus.mem_vis_addr), 64'h20);
        wait_finish(1'b1);
        wait_finish(1'b1);

        // all four ports request continuously after a fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int p = 0; p < NP; p++) set_req(p, 2'b01, AW'(17'h00400 + p), 32'h0, 3'd0, 4'd0);
        for (int t = 0; t < 5; t++) begin
            int ep;
            ep = RR ? (t % NP) : 0;
            push(ep, AW'(17'h00400 + ep));
        end
        for (int t = 0; t < 5; t++) begin
            wait_finish(1'b0);
            if (t < 4 && sb.size() > 0) begin
                @(negedge clk);
                check("b2b_mem_vis", 64'(bus.mem_vis_signal), 64'd1);
                check("b2b_grant", 64'(bus.grant_id), 64'(sb[0].port));
            end
        end
        bus.req_vis_signal = '0;
        repeat (3) @(negedge clk);
        check("end_mem_idle", 64'(bus.mem_vis_signal), 64'd0);
        check("end_queue_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
